// File: rtl/vending_pkg.sv
// Shared coin definitions for the vending controller, balance monitor and coin dispenser.
package vending_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t NONE    = 2'd0;
    localparam coin_t NICKEL  = 2'd1;
    localparam coin_t DIME    = 2'd2;
    localparam coin_t QUARTER = 2'd3;

    // Coin worth in nickel-equivalents.
    function automatic logic [2:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  return 3'd1;
            DIME:    return 3'd2;
            QUARTER: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small power-of-two FIFO for coin codes with wrapping pointers and a separate occupancy count.
module coin_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/coin_dispenser.sv
// Queues change-coin requests and fires the hopper one coin at a time with jam detection.
// Define COIN_DISPENSER_STATS_EN to enable the saturating n_nickel/n_dime/n_quarter counters.
module coin_dispenser
    import vending_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 15,
    parameter int CNT_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               change_in,
    input  logic                     coin_sensed,
    input  logic                     jam_clear,
    output logic                     eject_valid,
    output logic [1:0]               eject_coin,
    output logic                     busy,
    output logic                     jam,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [CNT_BITS-1:0]      n_nickel,
    output logic [CNT_BITS-1:0]      n_dime,
    output logic [CNT_BITS-1:0]      n_quarter
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, GAP, JAM} state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    coin_t         coin_reg;
    coin_t         fifo_head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign push = (change_in != NONE);

    coin_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (change_in),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (pending)
    );

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = PULSE;
                end
            end
            PULSE: begin
                timer_nx = TW'(TIMEOUT);
                state_nx = WAIT;
            end
            WAIT: begin
                // The sensor wins even on the cycle the timer runs out.
                if (coin_sensed) begin
                    state_nx = GAP;
                end else begin
                    timer_nx = timer - 1'b1;
                    if (timer == TW'(1))
                        state_nx = JAM;
                end
            end
            GAP:     state_nx = IDLE;
            JAM: begin
                if (jam_clear)
                    state_nx = PULSE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // The coin register is retried after a jam, so it only changes on a pop.
    always_ff @(posedge clock) begin
        if (pop)
            coin_reg <= fifo_head;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (push && fifo_full && !pop)
            overflow <= 1'b1;
    end

    assign eject_valid = (state == PULSE);
    assign eject_coin  = eject_valid ? coin_reg : NONE;
    assign jam         = (state == JAM);
    assign busy        = (pending != '0) || (state != IDLE);

`ifdef COIN_DISPENSER_STATS_EN
    logic count_en;

    assign count_en = (state == WAIT) && coin_sensed;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_nickel  <= '0;
            n_dime    <= '0;
            n_quarter <= '0;
        end else if (count_en) begin
            case (coin_reg)
                NICKEL:  n_nickel  <= sat_inc(n_nickel);
                DIME:    n_dime    <= sat_inc(n_dime);
                QUARTER: n_quarter <= sat_inc(n_quarter);
                default: ;
            endcase
        end
    end
`else
    assign n_nickel  = '0;
    assign n_dime    = '0;
    assign n_quarter = '0;
`endif

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: directed scenarios plus a randomized stream checked
// against a queue-based model of the requested coins.
module tb_coin_dispenser;

    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 15;
    localparam int CNT_BITS = 4;
    localparam int PW       = $clog2(DEPTH) + 1;
    localparam int CMAX     = (1 << CNT_BITS) - 1;

`ifdef COIN_DISPENSER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [1:0]          change_in = 2'd0;
    logic                coin_sensed = 1'b0;
    logic                jam_clear = 1'b0;
    logic                eject_valid;
    logic [1:0]          eject_coin;
    logic                busy;
    logic                jam;
    logic                overflow;
    logic [PW-1:0]       pending;
    logic [CNT_BITS-1:0] n_nickel;
    logic [CNT_BITS-1:0] n_dime;
    logic [CNT_BITS-1:0] n_quarter;

    int total = 0;
    int bad   = 0;
    int exp_cnt[4];

    always #5 clock = ~clock;

    coin_dispenser #(
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .change_in   (change_in),
        .coin_sensed (coin_sensed),
        .jam_clear   (jam_clear),
        .eject_valid (eject_valid),
        .eject_coin  (eject_coin),
        .busy        (busy),
        .jam         (jam),
        .overflow    (overflow),
        .pending     (pending),
        .n_nickel    (n_nickel),
        .n_dime      (n_dime),
        .n_quarter   (n_quarter)
    );

    // Reference statistics: one successful sense of coin c, saturating at all-ones.
    function automatic void model_sense(input int c);
        if (exp_cnt[c] < CMAX)
            exp_cnt[c] = exp_cnt[c] + 1;
    endfunction

    function automatic int exp_stat(input int c);
        return STATS ? exp_cnt[c] : 0;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; change_in = 2'd0; coin_sensed = 1'b0; jam_clear = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = '{0, 0, 0, 0};
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({eject_valid, eject_coin, busy, jam, overflow} !== 6'd0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000", {eject_valid, eject_coin, busy, jam, overflow});
        end
        total++;
        if (pending !== PW'(0)) begin
            bad++; $display("FAIL reset_pending got=%0d want=0", pending);
        end
        total++;
        if ({n_nickel, n_dime, n_quarter} !== '0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", n_nickel, n_dime, n_quarter);
        end
    endtask

    task automatic test_single_dime();
        change_in = 2'd2;
        @(negedge clock);
        change_in = 2'd0;
        total++;
        if (pending !== PW'(1) || eject_valid !== 1'b0) begin
            bad++; $display("FAIL dime_queued pending=%0d ev=%b want pending=1 ev=0", pending, eject_valid);
        end
        @(negedge clock);
        total++;
        if (eject_valid !== 1'b1 || eject_coin !== 2'd2) begin
            bad++; $display("FAIL dime_eject ev=%b coin=%0d want ev=1 coin=2", eject_valid, eject_coin);
        end
        @(negedge clock);
        @(negedge clock);
        coin_sensed = 1'b1;
        @(negedge clock);
        coin_sensed = 1'b0;
        model_sense(2);
        total++;
        if (busy !== 1'b1 || eject_valid !== 1'b0) begin
            bad++; $display("FAIL dime_gap busy=%b ev=%b want busy=1 ev=0", busy, eject_valid);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL dime_idle busy=%b want 0", busy);
        end
        total++;
        if (n_dime !== CNT_BITS'(exp_stat(2))) begin
            bad++; $display("FAIL dime_count got=%0d want=%0d", n_dime, exp_stat(2));
        end
    endtask

    task automatic test_in_order();
        int ej_t[$];
        int ej_c[$];
        int peak = 0;
        int cd = 0;
        for (int t = 0; t < 24; t++) begin
            coin_sensed = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    coin_sensed = 1'b1;
                    model_sense(ej_c[$]);
                end
            end
            if (eject_valid === 1'b1) begin
                ej_t.push_back(t);
                ej_c.push_back(int'(eject_coin));
                cd = 1;
            end
            if (int'(pending) > peak)
                peak = int'(pending);
            change_in = (t == 0) ? 2'd1 : (t == 1) ? 2'd3 : (t == 2) ? 2'd2 : 2'd0;
            @(negedge clock);
        end
        coin_sensed = 1'b0;
        total++;
        if (ej_c.size() != 3) begin
            bad++; $display("FAIL order_count got=%0d want=3", ej_c.size());
        end else begin
            total++;
            if (ej_c[0] != 1 || ej_c[1] != 3 || ej_c[2] != 2) begin
                bad++; $display("FAIL order_coins got=%0d,%0d,%0d want=1,3,2", ej_c[0], ej_c[1], ej_c[2]);
            end
            total++;
            if (ej_t[0] != 2 || ej_t[1] != 6 || ej_t[2] != 10) begin
                bad++; $display("FAIL order_timing got=%0d,%0d,%0d want=2,6,10", ej_t[0], ej_t[1], ej_t[2]);
            end
        end
        total++;
        if (peak != 2 || overflow !== 1'b0) begin
            bad++; $display("FAIL order_peak peak=%0d ovf=%b want peak=2 ovf=0", peak, overflow);
        end
        total++;
        if (n_nickel !== CNT_BITS'(exp_stat(1)) || n_quarter !== CNT_BITS'(exp_stat(3)) ||
            n_dime !== CNT_BITS'(exp_stat(2))) begin
            bad++; $display("FAIL order_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", n_nickel, n_dime,
                            n_quarter, exp_stat(1), exp_stat(2), exp_stat(3));
        end
    endtask

    task automatic test_overflow();
        change_in = 2'd1;
        @(negedge clock);
        change_in = 2'd0;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) begin
            change_in = 2'd3;
            @(negedge clock);
        end
        total++;
        if (pending !== PW'(DEPTH) || overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_full pending=%0d ovf=%b want pending=%0d ovf=0", pending, overflow, DEPTH);
        end
        @(negedge clock);
        change_in = 2'd0;
        total++;
        if (pending !== PW'(DEPTH) || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_drop pending=%0d ovf=%b want pending=%0d ovf=1", pending, overflow, DEPTH);
        end
        repeat (12) @(negedge clock);
        total++;
        if (overflow !== 1'b1 || jam !== 1'b1 || pending !== PW'(DEPTH)) begin
            bad++; $display("FAIL ovf_sticky ovf=%b jam=%b pending=%0d want 1/1/%0d", overflow, jam, pending, DEPTH);
        end
        apply_reset();
        total++;
        if (overflow !== 1'b0 || pending !== PW'(0)) begin
            bad++; $display("FAIL ovf_cleared ovf=%b pending=%0d want 0/0", overflow, pending);
        end
    endtask

    task automatic test_jam();
        change_in = 2'd1;
        @(negedge clock);
        change_in = 2'd0;
        @(negedge clock);
        repeat (TIMEOUT) @(negedge clock);
        total++;
        if (jam !== 1'b0) begin
            bad++; $display("FAIL jam_early jam=%b want 0", jam);
        end
        @(negedge clock);
        total++;
        if (jam !== 1'b1 || eject_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL jam_set jam=%b ev=%b busy=%b want 1/0/1", jam, eject_valid, busy);
        end
        coin_sensed = 1'b1;
        @(negedge clock);
        coin_sensed = 1'b0;
        @(negedge clock);
        total++;
        if (jam !== 1'b1) begin
            bad++; $display("FAIL jam_ignore_sense jam=%b want 1", jam);
        end
        jam_clear = 1'b1;
        @(negedge clock);
        jam_clear = 1'b0;
        total++;
        if (eject_valid !== 1'b1 || eject_coin !== 2'd1 || jam !== 1'b0) begin
            bad++; $display("FAIL jam_retry ev=%b coin=%0d jam=%b want 1/1/0", eject_valid, eject_coin, jam);
        end
        @(negedge clock);
        coin_sensed = 1'b1;
        @(negedge clock);
        coin_sensed = 1'b0;
        model_sense(1);
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || jam !== 1'b0 || n_nickel !== CNT_BITS'(exp_stat(1))) begin
            bad++; $display("FAIL jam_done busy=%b jam=%b n_nickel=%0d want 0/0/%0d", busy, jam, n_nickel, exp_stat(1));
        end
    endtask

    task automatic test_expiry_sense();
        change_in = 2'd3;
        @(negedge clock);
        change_in = 2'd0;
        @(negedge clock);
        repeat (TIMEOUT) @(negedge clock);
        coin_sensed = 1'b1;
        @(negedge clock);
        coin_sensed = 1'b0;
        model_sense(3);
        total++;
        if (jam !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL expiry_gap jam=%b busy=%b want 0/1", jam, busy);
        end
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || jam !== 1'b0 || n_quarter !== CNT_BITS'(exp_stat(3))) begin
            bad++; $display("FAIL expiry_done busy=%b jam=%b n_quarter=%0d want 0/0/%0d", busy, jam, n_quarter, exp_stat(3));
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        change_in = 2'd2;
        @(negedge clock);
        change_in = 2'd1;
        @(negedge clock);
        change_in = 2'd3;
        @(negedge clock);
        change_in = 2'd0;
        total++;
        if (pending !== PW'(2) || busy !== 1'b1) begin
            bad++; $display("FAIL mid_queued pending=%0d busy=%b want 2/1", pending, busy);
        end
        #2 reset = 1'b1;
        #1;
        exp_cnt = '{0, 0, 0, 0};
        total++;
        if ({eject_valid, eject_coin, busy, jam, overflow} !== 6'd0 || pending !== PW'(0) ||
            {n_nickel, n_dime, n_quarter} !== '0) begin
            bad++; $display("FAIL mid_async flags=%b pending=%0d want 000000/0",
                            {eject_valid, eject_coin, busy, jam, overflow}, pending);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (eject_valid !== 1'b0 || busy !== 1'b0)
                seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL mid_quiet activity_after_reset=1 want 0");
        end
    endtask

    // Random request/sense stream; q holds exactly the coins that should be sitting in the FIFO.
    task automatic run_stream(input string name, input int n_req, input int fixed_coin);
        int  q[$];
        int  issued = 0;
        int  cd = 0;
        int  cyc = 0;
        int  fly = -1;
        int  c;
        bit  done = 1'b0;
        while (!done) begin
            coin_sensed = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    coin_sensed = 1'b1;
                    model_sense(fly);
                    fly = -1;
                end
            end
            total++;
            if (eject_valid === 1'b1) begin
                if (q.size() == 0 || eject_coin !== 2'(q[0])) begin
                    bad++;
                    $display("FAIL %s_order got=%0d want=%0d", name, eject_coin, (q.size() == 0) ? 0 : q[0]);
                end
                fly = (q.size() > 0) ? q.pop_front() : int'(eject_coin);
                cd = $urandom_range(1, 4);
            end else if (eject_coin !== 2'd0) begin
                bad++; $display("FAIL %s_idle_coin got=%0d want=0", name, eject_coin);
            end
            total++;
            if (pending !== PW'(q.size())) begin
                bad++; $display("FAIL %s_pending got=%0d want=%0d", name, pending, q.size());
            end
            change_in = 2'd0;
            if (issued < n_req && q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                c = (fixed_coin != 0) ? fixed_coin : int'($urandom_range(1, 3));
                change_in = 2'(c);
                q.push_back(c);
                issued++;
            end
            cyc++;
            if (issued == n_req && q.size() == 0 && cd == 0 && fly < 0 && busy === 1'b0) begin
                done = 1'b1;
            end else if (cyc > 3000) begin
                total++; bad++;
                $display("FAIL %s_timeout issued=%0d left=%0d want all coins dispensed", name, issued, q.size());
                done = 1'b1;
            end
            @(negedge clock);
        end
        coin_sensed = 1'b0;
        change_in = 2'd0;
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL %s_overflow got=%b want=0", name, overflow);
        end
        total++;
        if (n_nickel !== CNT_BITS'(exp_stat(1)) || n_dime !== CNT_BITS'(exp_stat(2)) ||
            n_quarter !== CNT_BITS'(exp_stat(3))) begin
            bad++; $display("FAIL %s_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", name, n_nickel, n_dime,
                            n_quarter, exp_stat(1), exp_stat(2), exp_stat(3));
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_stream("random", 40, 0);
    endtask

    task automatic test_saturation();
        apply_reset();
        run_stream("sat", 16, 1);
        total++;
        if (n_nickel !== CNT_BITS'(STATS ? CMAX : 0)) begin
            bad++; $display("FAIL sat_nickel got=%0d want=%0d", n_nickel, STATS ? CMAX : 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_dime();
        test_in_order();
        test_overflow();
        test_jam();
        test_expiry_sense();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
